// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-to-1 valid/ready channel mux feeding a 2-entry output buffer; MUX_RR_EN adds round-robin arbitration.
// Latency: one cycle from accepting edge to out_valid/out_data.
// Backpressure: in_ready is low for every channel while the buffer holds 2 entries; head holds while out_ready is low.
//
// Build option: define MUX_RR_EN to honour rr_mode (round-robin grant with rr_ptr state).
// Without it rr_mode is ignored and the grant always follows sel.

// Generic synchronous FIFO: write when wr_vld and not full, read when rd_rdy and not empty.
// rd_dat shows the head entry combinationally; storage is cleared on reset so the head reads zero.
module fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_vld,
  input  logic [DW-1:0] wr_dat,
  output logic          full,
  output logic          empty,
  input  logic          rd_rdy,
  output logic [DW-1:0] rd_dat
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          wr_en;
  logic          rd_en;

  // Qualify the requests against the occupancy.
  always_comb begin
    full   = (count == CW'(DEPTH));
    empty  = (count == '0);
    wr_en  = wr_vld && !full;
    rd_en  = rd_rdy && !empty;
    rd_dat = mem[rd_ptr];
  end

  // Storage and write pointer; entries are zeroed on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_dat;
      wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

  // Read pointer and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rd_en) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module mux_nx1_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);
  // Buffer entry: channel index in the upper bits, data in the lower bits.
  typedef struct packed {
    logic [SEL_W-1:0] ch;
    logic [WIDTH-1:0] dat;
  } entry_t;

  logic             rr_on;
  logic             sel_ok;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_in_vld;
  logic [WIDTH-1:0] gnt_dat;
  logic             push;
  logic             buf_full;
  logic             buf_empty;
  entry_t           push_ent;
  entry_t           head_ent;

  // Only indices below NUM_IN name a real channel; the rest are illegal selects.
  assign sel_ok = (int'(sel) < NUM_IN);

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;

  assign rr_on = rr_mode;

  // Channel index base+off, wrapped back into 0..NUM_IN-1.
  function automatic logic [SEL_W-1:0] wrap_idx(input logic [SEL_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_IN) begin
      s = s - NUM_IN;
    end
    return s[SEL_W-1:0];
  endfunction

  // Grant: round-robin scan starting just above the last winner, or the selected channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (rr_on) begin
      for (int i = 1; i <= NUM_IN; i++) begin
        if (!gnt_vld && in_valid[wrap_idx(rr_ptr, i)]) begin
          gnt_vld = 1'b1;
          gnt_idx = wrap_idx(rr_ptr, i);
        end
      end
    end else if (sel_ok) begin
      gnt_vld = 1'b1;
      gnt_idx = sel;
    end
  end

  // Remember the last accepted round-robin winner; select-mode traffic leaves it alone.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr <= SEL_W'(NUM_IN - 1);
    end else if (push && rr_on) begin
      rr_ptr <= gnt_idx;
    end
  end
`else
  logic unused_rr_mode;

  assign rr_on          = 1'b0;
  assign unused_rr_mode = rr_mode;

  // Grant: the selected channel, provided it exists.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (sel_ok) begin
      gnt_vld = 1'b1;
      gnt_idx = sel;
    end
  end
`endif

  // Steer the granted channel's valid and data, and raise only its ready while there is room.
  always_comb begin
    gnt_in_vld = 1'b0;
    gnt_dat    = '0;
    in_ready   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (gnt_idx == SEL_W'(k)) begin
        gnt_in_vld = in_valid[k];
        gnt_dat    = in_data[k*WIDTH +: WIDTH];
        in_ready[k] = gnt_vld && !buf_full;
      end
    end
  end

  assign push         = gnt_vld && !buf_full && gnt_in_vld;
  assign push_ent.ch  = gnt_idx;
  assign push_ent.dat = gnt_dat;

  fifo #(
    .DW    ($bits(entry_t)),
    .DEPTH (2)
  ) u_buf (
    .clk    (CLK),
    .rst_n  (RESET),
    .wr_vld (push),
    .wr_dat (push_ent),
    .full   (buf_full),
    .empty  (buf_empty),
    .rd_rdy (out_ready),
    .rd_dat (head_ent)
  );

  assign out_valid = !buf_empty;
  assign out_data  = head_ent.dat;
  assign out_ch    = head_ent.ch;

  // Sticky flag for an out-of-range select seen in select mode; only reset clears it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sel_err <= 1'b0;
    end else if (!rr_on && !sel_ok) begin
      sel_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Directed bench for mux_nx1_pipe: default 4-channel instance plus a 3-channel instance for illegal selects.
// Inputs are driven 1ns after the rising edge; outputs are sampled at that same point.
// Works with or without MUX_RR_EN; the mode test follows the build option.
module tb_mux_nx1_pipe;
  logic        CLK;
  logic        RESET;

  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [1:0]  sel;
  logic        rr_mode;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        sel_err;

  logic [23:0] d3_in_data;
  logic [2:0]  d3_in_valid;
  logic [2:0]  d3_in_ready;
  logic [1:0]  d3_sel;
  logic        d3_rr_mode;
  logic [7:0]  d3_out_data;
  logic [1:0]  d3_out_ch;
  logic        d3_out_valid;
  logic        d3_out_ready;
  logic        d3_sel_err;

  int total;
  int bad;

  mux_nx1_pipe u_dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .rr_mode   (rr_mode),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  mux_nx1_pipe #(.WIDTH(8), .NUM_IN(3)) u_dut3 (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_data   (d3_in_data),
    .in_valid  (d3_in_valid),
    .in_ready  (d3_in_ready),
    .sel       (d3_sel),
    .rr_mode   (d3_rr_mode),
    .out_data  (d3_out_data),
    .out_ch    (d3_out_ch),
    .out_valid (d3_out_valid),
    .out_ready (d3_out_ready),
    .sel_err   (d3_sel_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (out_ch !== 2'd0) begin bad++; $display("FAIL reset_out_ch got=%0d want=0", out_ch); end
    total++; if (sel_err !== 1'b0) begin bad++; $display("FAIL reset_sel_err got=%b want=0", sel_err); end
    total++; if (d3_sel_err !== 1'b0) begin bad++; $display("FAIL reset_d3_sel_err got=%b want=0", d3_sel_err); end
    @(negedge CLK);
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A5_0000; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL basic_in_ready got=%b want=0100", in_ready); end
    tick();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_out_valid got=%b want=1", out_valid); end
    total++; if (out_data !== 8'hA5) begin bad++; $display("FAIL basic_out_data got=%h want=a5", out_data); end
    total++; if (out_ch !== 2'd2) begin bad++; $display("FAIL basic_out_ch got=%0d want=2", out_ch); end
    in_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0011;
    tick();
    in_data = 32'h0000_0022;
    #1;
    total++; if (in_ready !== 4'b0001) begin bad++; $display("FAIL bp_ready_one got=%b want=0001", in_ready); end
    tick();
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready_full got=%b want=0000", in_ready); end
    total++; if (out_data !== 8'h11) begin bad++; $display("FAIL bp_head got=%h want=11", out_data); end
    tick();
    total++; if (out_data !== 8'h11 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold got=%h/%0d/%b want=11/0/1", out_data, out_ch, out_valid);
    end
    in_valid = 4'b0000; out_ready = 1'b1;
    tick();
    total++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_second got=%h/%b want=22/1", out_data, out_valid);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_push_pop();
    sel = 2'd1; in_valid = 4'b0010; in_data = 32'h0000_3300; out_ready = 1'b1;
    tick();
    in_data = 32'h0000_4400;
    tick();
    total++; if (out_data !== 8'h44 || out_ch !== 2'd1 || out_valid !== 1'b1) begin
      bad++; $display("FAIL pushpop_head got=%h/%0d/%b want=44/1/1", out_data, out_ch, out_valid);
    end
    in_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL pushpop_drain got=%b want=0", out_valid); end
  endtask

`ifdef MUX_RR_EN
  task automatic test_mode();
    rr_mode = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1; sel = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_ch !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
        bad++; $display("FAIL rr_order step=%0d got=%0d/%h want=%0d/%h", i, out_ch, out_data, i % 4, 8'h10 + i % 4);
      end
    end
    in_valid = 4'b0000;
    #1;
    total++; if (in_ready !== 4'b0000) begin bad++; $display("FAIL rr_idle_ready got=%b want=0000", in_ready); end
    tick();
    in_valid = 4'b1010;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL rr_skip_ready got=%b want=0010", in_ready); end
    tick();
    total++; if (out_ch !== 2'd1 || out_data !== 8'h11) begin
      bad++; $display("FAIL rr_skip_out got=%0d/%h want=1/11", out_ch, out_data);
    end
    in_valid = 4'b0000; rr_mode = 1'b0;
    tick();
  endtask
`else
  task automatic test_mode();
    rr_mode = 1'b1; sel = 2'd1; in_valid = 4'b1111; in_data = 32'h1312_1110; out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL norr_ready got=%b want=0010", in_ready); end
    tick();
    total++; if (out_ch !== 2'd1 || out_data !== 8'h11) begin
      bad++; $display("FAIL norr_out got=%0d/%h want=1/11", out_ch, out_data);
    end
    in_valid = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL norr_drain got=%b want=0", out_valid); end
    rr_mode = 1'b0;
  endtask
`endif

  task automatic test_sel_err();
    d3_sel = 2'd3; d3_in_valid = 3'b111; d3_in_data = 24'hCC_BB_AA; d3_out_ready = 1'b1;
    #1;
    total++; if (d3_in_ready !== 3'b000) begin bad++; $display("FAIL selerr_ready got=%b want=000", d3_in_ready); end
    total++; if (d3_sel_err !== 1'b0) begin bad++; $display("FAIL selerr_before got=%b want=0", d3_sel_err); end
    tick();
    total++; if (d3_sel_err !== 1'b1 || d3_out_valid !== 1'b0) begin
      bad++; $display("FAIL selerr_set got=%b/%b want=1/0", d3_sel_err, d3_out_valid);
    end
    d3_sel = 2'd0;
    #1;
    total++; if (d3_in_ready !== 3'b001) begin bad++; $display("FAIL selerr_legal_ready got=%b want=001", d3_in_ready); end
    tick();
    total++; if (d3_sel_err !== 1'b1 || d3_out_valid !== 1'b1 || d3_out_data !== 8'hAA) begin
      bad++; $display("FAIL selerr_held got=%b/%b/%h want=1/1/aa", d3_sel_err, d3_out_valid, d3_out_data);
    end
    d3_in_valid = 3'b000;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; sel = 2'd0; in_valid = 4'b0001; in_data = 32'h0000_0055;
    tick();
    in_data = 32'h0000_0066;
    tick();
    in_valid = 4'b0000;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h55) begin
      bad++; $display("FAIL rstmid_loaded got=%b/%h want=1/55", out_valid, out_data);
    end
    #2;
    RESET = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      bad++; $display("FAIL rstmid_async got=%b/%h/%0d want=0/00/0", out_valid, out_data, out_ch);
    end
    total++; if (d3_sel_err !== 1'b0) begin bad++; $display("FAIL rstmid_sel_err got=%b want=0", d3_sel_err); end
    in_valid = 4'b0001;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_accept got=%b want=0", out_valid); end
    in_valid = 4'b0000;
    @(negedge CLK);
    RESET = 1'b1; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_empty got=%b want=0", out_valid); end
  endtask

  initial begin
    total = 0; bad = 0;
    RESET = 1'b0;
    in_data = '0; in_valid = '0; sel = '0; rr_mode = 1'b0; out_ready = 1'b0;
    d3_in_data = '0; d3_in_valid = '0; d3_sel = '0; d3_rr_mode = 1'b0; d3_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_push_pop();
    test_mode();
    test_sel_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
